// File: rtl/sram_burst_pkg.sv
// Shared types and constants for the SRAM burst controller.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Read-side output buffer depth and the width of its occupancy count.
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO that absorbs SRAM read latency and downstream backpressure.
// The producer never pushes into a full buffer unless it also pops that cycle.
module sram_rd_skid
  import sram_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  pop;

  assign pop_valid = (occ_q != '0);
  assign pop       = pop_valid & pop_ready;
  assign pop_data  = head_q;
  assign occ       = occ_q;

  // Entry storage and occupancy; the head register always holds the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (push_valid && pop) begin
      if (occ_q == OCC_W'(BUF_DEPTH)) begin
        head_q <= tail_q;
        tail_q <= push_data;
      end else begin
        head_q <= push_data;
      end
    end else if (pop) begin
      head_q <= tail_q;
      occ_q  <= occ_q - OCC_W'(1);
    end else if (push_valid) begin
      if (occ_q == '0) head_q <= push_data;
      else             tail_q <= push_data;
      occ_q <= occ_q + OCC_W'(1);
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst initiator for a single-port SRAM with 1-cycle registered read.
// Optional macro SRAM_BURST_RANGE_CHECK_EN: reject bursts that would run past
// RAM_SIZE-1 (no access, done next cycle, sticky range_err).
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RAM_SIZE   = 2048,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
`ifdef SRAM_BURST_RANGE_CHECK_EN
  output logic                  range_err,
`endif
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  ready_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] wdata_hold_q;
  logic [OCC_W-1:0]      occ;
  logic                  accept;
  logic                  access;
  logic                  access_we;
  logic                  rd_pop;
  logic                  cmd_bad;
  logic [2:0]            pending;
  logic [ADDR_WIDTH-1:0] addr_next;

  sram_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (inflight_q),
    .push_data  (sram_rdata),
    .pop_valid  (rd_valid),
    .pop_ready  (rd_ready),
    .pop_data   (rd_data),
    .occ        (occ)
  );

  // ready_q keeps cmd_ready low while reset is asserted even though state is IDLE.
  assign cmd_ready = (state_q == ST_IDLE) & ready_q;
  assign accept    = cmd_valid & cmd_ready;
  assign rd_pop    = rd_valid & rd_ready;
  // Words buffered or in flight after this cycle's pop, before any new issue.
  assign pending   = 3'(occ) + 3'(inflight_q) - 3'(rd_pop);
  assign addr_next = (addr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

`ifdef SRAM_BURST_RANGE_CHECK_EN
  localparam int unsigned SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SUM_W-1:0] cmd_end;
  assign cmd_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign cmd_bad = (cmd_end >= SUM_W'(RAM_SIZE));
`else
  assign cmd_bad = 1'b0;
`endif

  // Next-state and per-cycle SRAM access decision.
  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    done      = 1'b0;
    access    = 1'b0;
    access_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_bad)        state_d = ST_DRAIN;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          access    = 1'b1;
          access_we = 1'b1;
          if (cnt_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_READ: begin
        if (pending < 3'd2) begin
          access = 1'b1;
          if (cnt_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Also serves as the single done cycle after a write burst or a rejected command.
        if (occ == '0 && !inflight_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sram_en    = access;
  assign sram_we    = access_we;
  assign sram_addr  = access    ? addr_q  : addr_hold_q;
  assign sram_wdata = access_we ? wr_data : wdata_hold_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Burst address/count, read-in-flight flag and held SRAM bus values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      inflight_q   <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      inflight_q <= access & ~access_we;
      if (accept) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end else if (access) begin
        addr_q      <= addr_next;
        cnt_q       <= cnt_q - LEN_WIDTH'(1);
        addr_hold_q <= addr_q;
        if (access_we) wdata_hold_q <= wr_data;
      end
    end
  end

`ifdef SRAM_BURST_RANGE_CHECK_EN
  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 range_err <= 1'b0;
    else if (accept && cmd_bad) range_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl with a behavioural SRAM and a
// word-count reference model of the read/write burst rules.
module tb_sram_burst_ctrl;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 11;
  localparam int unsigned RS = 2048;
  localparam int unsigned LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
`ifdef SRAM_BURST_RANGE_CHECK_EN
  logic          range_err;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DW-1:0] sram_mem [RS];
  logic [DW-1:0] ref_mem  [RS];

  sram_burst_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_SIZE   (RS),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .done       (done),
`ifdef SRAM_BURST_RANGE_CHECK_EN
    .range_err  (range_err),
`endif
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
`ifdef SRAM_BURST_RANGE_CHECK_EN
    chk("rst_range_err", range_err, 0);
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("post_rst_cmd_ready_high", cmd_ready, 1);
  endtask

  // Offer a command from the current point; returns 1 time unit after the accept edge.
  task automatic send_cmd(input bit wr, input int unsigned a, input int unsigned len);
    int unsigned wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 50) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

`ifdef SRAM_BURST_RANGE_CHECK_EN
  task automatic range_tail();
    @(negedge clk);
    #1;
    chk("range_no_access", sram_en, 0);
    chk("range_done", done, 1);
    chk("range_err_set", range_err, 1);
    @(negedge clk);
    #1;
    chk("range_cmd_ready", cmd_ready, 1);
  endtask
`endif

  task automatic write_burst(input int unsigned a, input int unsigned len, input bit seq,
                             input int unsigned base, input int unsigned vmode);
    int unsigned n = 0;
    int unsigned cyc = 0;
    int unsigned last_a = 0;
    int unsigned exp_a;
    bit v;
    logic [DW-1:0] d;
    send_cmd(1'b1, a, len);
`ifdef SRAM_BURST_RANGE_CHECK_EN
    if (a + len >= RS) begin
      range_tail();
      return;
    end
`endif
    while (n < len + 1 && cyc < 4000) begin
      @(negedge clk);
      v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = seq ? DW'(base + n) : DW'($urandom_range(0, (1 << DW) - 1));
      wr_valid = v;
      wr_data  = d;
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("wr_en", sram_en, v);
      chk("wr_we", sram_we, v);
      chk("wr_busy", {cmd_ready, done, rd_valid}, 0);
      if (v) begin
        exp_a = (a + n) % RS;
        chk("wr_addr", sram_addr, exp_a);
        chk("wr_wdata", sram_wdata, d);
        ref_mem[exp_a] = d;
        last_a = exp_a;
        n++;
      end
      cyc++;
    end
    chk("wr_word_count", n, len + 1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_ready_after", wr_ready, 0);
    chk("wr_idle_no_access", sram_en, 0);
    chk("wr_hold_addr", sram_addr, last_a);
    @(negedge clk);
    #1;
    chk("wr_cmd_ready_after_done", cmd_ready, 1);
    chk("wr_done_single", done, 0);
  endtask

  // mode 0: rd_ready held high; 1: pattern 1,0,0,1; 2: random.
  task automatic read_burst(input int unsigned a, input int unsigned len, input int unsigned mode,
                            input int unsigned abort_at);
    int unsigned remaining = len + 1;
    int unsigned issued = 0;
    int unsigned popped = 0;
    int unsigned iss_prev = 0;
    int unsigned visible, outstanding;
    int unsigned cyc = 0;
    bit r, pop, exp_issue;
    send_cmd(1'b0, a, len);
`ifdef SRAM_BURST_RANGE_CHECK_EN
    if (a + len >= RS) begin
      range_tail();
      return;
    end
`endif
    while (popped < len + 1 && cyc < 4000) begin
      @(negedge clk);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      #1;
      // Issued two or more cycles ago and not yet consumed -> visible in the buffer.
      visible     = issued - iss_prev - popped;
      outstanding = issued - popped;
      pop         = (visible > 0) && r;
      exp_issue   = (remaining > 0) && ((outstanding - 32'(pop)) < 2);
      chk("rd_valid", rd_valid, visible > 0);
      chk("rd_issue", sram_en, exp_issue);
      chk("rd_we_low", sram_we, 0);
      chk("rd_busy", {cmd_ready, done, wr_ready}, 0);
      if (exp_issue) chk("rd_addr", sram_addr, (a + issued) % RS);
      if (pop) chk("rd_data", rd_data, ref_mem[(a + popped) % RS]);
      popped    += 32'(pop);
      issued    += 32'(exp_issue);
      remaining -= 32'(exp_issue);
      iss_prev   = 32'(exp_issue);
      cyc++;
      if (popped == abort_at) return;
    end
    chk("rd_word_count", popped, len + 1);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    chk("rd_done", done, 1);
    chk("rd_valid_after", rd_valid, 0);
    chk("rd_idle_no_access", sram_en, 0);
    @(negedge clk);
    #1;
    chk("rd_cmd_ready_after_done", cmd_ready, 1);
    chk("rd_done_single", done, 0);
  endtask

  initial begin
    for (int i = 0; i < RS; i++) begin
      ref_mem[i]  = DW'($urandom_range(0, (1 << DW) - 1));
      sram_mem[i] = ref_mem[i];
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    release_reset();

    // Write addr 5, len 3, continuous data 0x101..0x104.
    write_burst(5, 3, 1'b1, 'h101, 0);
    for (int i = 0; i < 4; i++) chk("mem_after_write", sram_mem[5 + i], 'h101 + i);

    // Read it back at full rate.
    read_burst(5, 3, 0, 32'hFFFF_FFFF);

    // Len 7 with random write stalls, then read with rd_ready 1,0,0,1.
    write_burst(20, 7, 1'b0, 0, 1);
    read_burst(20, 7, 1, 32'hFFFF_FFFF);

    // Address wrap at the top of the array (rejected when range checking is on).
    write_burst(2046, 3, 1'b1, 'h3A0, 0);
    read_burst(2046, 3, 2, 32'hFFFF_FFFF);

    // Reset during the 3rd word of a 10-word read.
    read_burst(100, 9, 0, 2);
    @(negedge clk);
    rst_n     = 1'b0;
    rd_ready  = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_reset_values();
    release_reset();
    read_burst(5, 3, 0, 32'hFFFF_FFFF);

    // Alternating write/read commands back to back with random parameters.
    for (int k = 0; k < 8; k++) begin
      int unsigned a, l;
      a = $urandom_range(0, RS - 1);
      l = $urandom_range(0, 15);
      write_burst(a, l, 1'b0, 0, 1);
      read_burst(a, l, 2, 32'hFFFF_FFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
